// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant/enable bundle between the bus arbiter and the bufz driver bank.
// Latency: none, wires only.
// Backpressure: none; REQ is level-sensitive and must be held until served.
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  REQ;
    logic [N-1:0]  GNT;
    logic [N-1:0]  EN;
    logic [OW-1:0] OWNER;
    logic          BUSY;

    // Arbiter side: samples requests, drives grants and driver enables.
    modport master (
        input  REQ,
        output GNT,
        output EN,
        output OWNER,
        output BUSY
    );

    // Requester / driver-bank side.
    modport slave (
        output REQ,
        input  GNT,
        input  EN,
        input  OWNER,
        input  BUSY
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus; one EN high at a time, TA all-off cycles between owners.
// Latency: REQ sampled in IDLE -> EN after that edge; owner release -> next EN after TA further edges.
// Backpressure: REQ is held by the requester until served; nothing is latched. Tenure limit via TRISTATE_BUS_ARBITER_TIMEOUT_EN.
module tristate_bus_arbiter #(
    parameter int N       = 4,
    parameter int TA      = 1,
    parameter int MAXHOLD = 16
) (
    input  logic                   CLK,
    input  logic                   RN,
    tristate_bus_arbiter_if.master bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Reject illegal configurations at elaboration.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("tristate_bus_arbiter: N out of range 2..16");
    end
    if (TA < 1 || TA > 7) begin : g_bad_ta
        $error("tristate_bus_arbiter: TA out of range 1..7");
    end
    if (MAXHOLD < 2 || MAXHOLD > 255) begin : g_bad_maxhold
        $error("tristate_bus_arbiter: MAXHOLD out of range 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] owner;
    logic [N-1:0]  gnt;
    logic          busy;
    logic [2:0]    ta_cnt;

    logic          win_vld;
    logic [OW-1:0] win_idx;
    logic [N-1:0]  win_onehot;
    logic [OW-1:0] ptr_next;
    logic          grant_load;
    logic          release_now;

    // Round-robin pick: first asserted REQ scanning upward from ptr, wrapping at N.
    // Scanning in reverse priority order lets the highest-priority hit overwrite the rest.
    always_comb begin
        int j;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (bus.REQ[j]) begin
                win_vld = 1'b1;
                win_idx = OW'(j);
            end
        end
    end

    // One-hot grant vector for the winner and the pointer that follows the current owner.
    always_comb begin
        win_onehot = ONE << win_idx;
        ptr_next   = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
    end

    // Arbitration points: IDLE, or the last cycle of the turnaround.
    assign grant_load = win_vld && ((state == IDLE) || (state == TURN && ta_cnt == 3'd0));

`ifdef TRISTATE_BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAXHOLD - 1);

    logic [7:0] tenure;
    logic       others_req;

    // A competing request is any REQ bit outside the current owner.
    assign others_req  = |(bus.REQ & ~gnt);
    // Owner dropping REQ and the limit firing together is one ordinary release.
    assign release_now = !bus.REQ[owner] || (tenure == HOLD_LIM && others_req);

    // Tenure counter: clears when a grant is issued, counts GRANT cycles, saturates at the limit.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            tenure <= 8'd0;
        end else if (grant_load) begin
            tenure <= 8'd0;
        end else if (state == GRANT && tenure != HOLD_LIM) begin
            tenure <= tenure + 8'd1;
        end
    end
`else
    // Without a tenure limit the owner keeps the bus as long as its REQ stays high.
    assign release_now = !bus.REQ[owner];
`endif

    // Main sequencer: all outputs are registered here so EN never depends combinationally on REQ.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            gnt    <= '0;
            busy   <= 1'b0;
            ta_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_load) begin
                        state <= GRANT;
                        gnt   <= win_onehot;
                        owner <= win_idx;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state  <= TURN;
                        gnt    <= '0;
                        owner  <= '0;
                        busy   <= 1'b0;
                        ptr    <= ptr_next;
                        ta_cnt <= 3'(TA - 1);
                    end
                end
                TURN: begin
                    if (ta_cnt != 3'd0) begin
                        ta_cnt <= ta_cnt - 3'd1;
                    end else if (grant_load) begin
                        state <= GRANT;
                        gnt   <= win_onehot;
                        owner <= win_idx;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    owner  <= '0;
                    busy   <= 1'b0;
                    ta_cnt <= 3'd0;
                end
            endcase
        end
    end

    // EN mirrors GNT bit-for-bit; both come straight from the grant flops.
    assign bus.GNT   = gnt;
    assign bus.EN    = gnt;
    assign bus.OWNER = owner;
    assign bus.BUSY  = busy;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for the tri-state bus arbiter with N=4, TA=3, MAXHOLD=16.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; requests are driven directly on the interface.
module tb_tristate_bus_arbiter;
    localparam int N       = 4;
    localparam int TA      = 3;
    localparam int MAXHOLD = 16;

    logic clk;
    logic rn;
    int   checks;
    int   passes;

    tristate_bus_arbiter_if #(.N(N)) bus ();

    tristate_bus_arbiter #(
        .N       (N),
        .TA      (TA),
        .MAXHOLD (MAXHOLD)
    ) dut (
        .CLK (clk),
        .RN  (rn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Brief mid-cycle reset pulse: returns to IDLE with ptr=0.
    task automatic pulse_reset();
        rn = 1'b0;
        #1;
        rn = 1'b1;
    endtask

    // Invariants checked on every falling edge out of reset.
    always @(negedge clk) begin
        if (rn === 1'b1) begin
            checks++;
            assert ($onehot0(bus.EN) && bus.EN === bus.GNT && bus.BUSY === (|bus.EN)) passes++;
            else $error("FAIL invariant EN=%b GNT=%b BUSY=%b", bus.EN, bus.GNT, bus.BUSY);
        end
    end

    initial begin
        checks  = 0;
        passes  = 0;
        rn      = 1'b0;
        bus.REQ = 4'b0000;
        #1;
        chk("rst_en",    32'(bus.EN),    32'h0);
        chk("rst_gnt",   32'(bus.GNT),   32'h0);
        chk("rst_busy",  32'(bus.BUSY),  32'h0);
        chk("rst_owner", 32'(bus.OWNER), 32'h0);
        step();
        step();
        rn = 1'b1;

        // Reset mid-grant, then first grant one edge after release.
        bus.REQ = 4'b0001;
        step();
        chk("g0_en",    32'(bus.EN),   32'h1);
        chk("g0_busy",  32'(bus.BUSY), 32'h1);
        step();
        chk("g0_hold",  32'(bus.EN),   32'h1);
        #2;
        rn = 1'b0;
        #1;
        chk("arst_en",    32'(bus.EN),    32'h0);
        chk("arst_busy",  32'(bus.BUSY),  32'h0);
        chk("arst_owner", 32'(bus.OWNER), 32'h0);
        rn = 1'b1;
        step();
        chk("post_rst_en", 32'(bus.EN), 32'h1);

        // Simultaneous requests from ptr=0: 1 wins, then 3 after TA idle cycles.
        pulse_reset();
        bus.REQ = 4'b1010;
        step();
        chk("sim_en",    32'(bus.EN),    32'h2);
        chk("sim_owner", 32'(bus.OWNER), 32'h1);
        step();
        step();
        chk("sim_hold", 32'(bus.EN), 32'h2);
        bus.REQ = 4'b1000;
        step();
        chk("sim_rel_en",    32'(bus.EN),    32'h0);
        chk("sim_rel_owner", 32'(bus.OWNER), 32'h0);
        chk("sim_rel_busy",  32'(bus.BUSY),  32'h0);
        step();
        chk("sim_ta2", 32'(bus.EN), 32'h0);
        step();
        chk("sim_ta3", 32'(bus.EN), 32'h0);
        step();
        chk("sim_next_en",    32'(bus.EN),    32'h8);
        chk("sim_next_owner", 32'(bus.OWNER), 32'h3);

        // Wrap: owner 3 releases with 0 and 2 pending -> ptr wraps to 0, so 0 wins.
        bus.REQ = 4'b0101;
        step();
        chk("wrap_rel", 32'(bus.EN), 32'h0);
        step();
        step();
        chk("wrap_ta", 32'(bus.EN), 32'h0);
        step();
        chk("wrap_en",    32'(bus.EN),    32'h1);
        chk("wrap_owner", 32'(bus.OWNER), 32'h0);

        // Owner 0 drops; from ptr=1, requester 1 wins after TA cycles.
        bus.REQ = 4'b0110;
        step();
        chk("ta_a_rel", 32'(bus.EN), 32'h0);
        step();
        step();
        chk("ta_a_low", 32'(bus.EN), 32'h0);
        step();
        chk("ta_a_en", 32'(bus.EN), 32'h2);

        // Turnaround TA=3: owner 1 drops with REQ[2] high.
        bus.REQ = 4'b0100;
        step();
        chk("ta_b_low1", 32'(bus.EN), 32'h0);
        step();
        chk("ta_b_low2", 32'(bus.EN), 32'h0);
        step();
        chk("ta_b_low3", 32'(bus.EN), 32'h0);
        step();
        chk("ta_b_en",    32'(bus.EN),    32'h4);
        chk("ta_b_owner", 32'(bus.OWNER), 32'h2);

        // Non-owner request during a grant is ignored.
        bus.REQ = 4'b0101;
        step();
        step();
        chk("ignore_other", 32'(bus.EN), 32'h4);

        // All requests drop: turnaround then IDLE.
        bus.REQ = 4'b0000;
        for (int i = 0; i < TA + 2; i++) begin
            step();
        end
        chk("idle_en",   32'(bus.EN),   32'h0);
        chk("idle_busy", 32'(bus.BUSY), 32'h0);

`ifdef TRISTATE_BUS_ARBITER_TIMEOUT_EN
        // Tenure limit with a competitor: EN=0001 for exactly MAXHOLD cycles.
        pulse_reset();
        bus.REQ = 4'b0011;
        step();
        chk("to_first", 32'(bus.EN), 32'h1);
        for (int i = 1; i < MAXHOLD; i++) begin
            step();
            chk("to_hold", 32'(bus.EN), 32'h1);
        end
        step();
        chk("to_rel", 32'(bus.EN), 32'h0);
        step();
        step();
        chk("to_ta", 32'(bus.EN), 32'h0);
        step();
        chk("to_next", 32'(bus.EN), 32'h2);

        // No competitor: owner keeps the bus well past MAXHOLD.
        bus.REQ = 4'b0001;
        step();
        chk("to_solo_rel", 32'(bus.EN), 32'h0);
        step();
        step();
        step();
        chk("to_solo_en", 32'(bus.EN), 32'h1);
        for (int i = 0; i < MAXHOLD + 8; i++) begin
            step();
        end
        chk("to_solo_hold", 32'(bus.EN), 32'h1);
`else
        // No tenure limit: owner 0 keeps the bus despite a competitor.
        pulse_reset();
        bus.REQ = 4'b0011;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("nto_hold", 32'(bus.EN), 32'h1);
        end
`endif

        bus.REQ = 4'b0000;
        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
